// File: rtl/register_file_2r1w.sv
// DEPTH x WIDTH register file: two registered read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero r0 and a sequential clear sweep.
module register_file_2r1w #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] read_index_a,
   output logic [WIDTH-1:0] read_data_a,
   input  logic [IDX_W-1:0] read_index_b,
   output logic [WIDTH-1:0] read_data_b,
   input  logic [IDX_W-1:0] write_index,
   input  logic             write_enable,
   input  logic [WIDTH-1:0] write_data,
   input  logic             clear_start,
   output logic             clear_busy
);

   localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(DEPTH - 1);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_next_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_a;
   logic [WIDTH-1:0] r_rd_b;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;
   logic             w_wr_ok;
   logic             w_sweep;

   assign w_sweep = (r_state == SWEEP);
   assign w_wr_ok = write_enable && !w_sweep && ({1'b0, write_index} < DEPTH_C) &&
                    !((ZERO_REG == 1) && (write_index == '0));

   // Out-of-range indices never match an entry, so they fall through to zero.
   function automatic logic [WIDTH-1:0] f_read(input logic [IDX_W-1:0] idx);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx == IDX_W'(i)) v = r_mem[i];
      end
      if ((ZERO_REG == 1) && (idx == '0)) v = '0;
      else if ((BYPASS == 1) && w_wr_ok && (idx == write_index)) v = write_data;
      return v;
   endfunction

   always_comb begin
      w_rd_a = f_read(read_index_a);
      w_rd_b = f_read(read_index_b);
   end

   always_comb begin
      w_next_state = r_state;
      w_next_ptr   = r_ptr;
      case (r_state)
         IDLE: begin
            if (clear_start) begin
               w_next_state = SWEEP;
               w_next_ptr   = '0;
            end
         end
         SWEEP: begin
            if (r_ptr == LAST_C) w_next_state = IDLE;
            else                 w_next_ptr   = r_ptr + 1'b1;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_next_state;
         r_ptr   <= w_next_ptr;
      end
   end

   // The sweep has priority; writes are already blocked while it runs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_sweep && (r_ptr == IDX_W'(i)))
               r_mem[i] <= '0;
            else if (w_wr_ok && (write_index == IDX_W'(i)))
               r_mem[i] <= write_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_a <= '0;
         r_rd_b <= '0;
      end else begin
         r_rd_a <= w_rd_a;
         r_rd_b <= w_rd_b;
      end
   end

   assign read_data_a = r_rd_a;
   assign read_data_b = r_rd_b;
   assign clear_busy  = w_sweep;

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised successor to the team's 4x16 single-read register file.
- Provides DEPTH registers of WIDTH bits, with:
  - two registered read ports;
  - one write port;
  - optional write-to-read bypass;
  - optional hardwired-zero register 0;
  - a sequential clear engine that zeroes the array one entry per cycle without a global reset.
- Sits between decode and execute in the datapath lab CPU.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; must be at least 2; need not be a power of two.
- IDX_W, $clog2(DEPTH), index width; derived, not overridden.
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns write_data; 0 = it returns the old value.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- read_index_a  in  IDX_W  read port A index.
- read_data_a  out  WIDTH  read port A data, registered.
- read_index_b  in  IDX_W  read port B index.
- read_data_b  out  WIDTH  read port B data, registered.
- write_index  in  IDX_W  write index.
- write_enable  in  1  write strobe.
- write_data  in  WIDTH  write data.
- clear_start  in  1  single-cycle request to start a clear sweep.
- clear_busy  out  1  high while the clear sweep is in progress.

Behaviour:
Reset:
- reset_n=0 acts immediately, independent of clk.
- All registers, read_data_a, read_data_b and the sweep pointer go to 0; clear_busy=0; FSM goes to IDLE.
- Reset asserted mid-sweep aborts the sweep. Array is still all zeros.

Write path:
- A write is accepted at posedge when all of these hold:
  - write_enable=1;
  - clear_busy=0;
  - write_index<DEPTH;
  - not (ZERO_REG=1 and write_index=0).
- On acceptance, reg[write_index] <= write_data. Otherwise the write is silently dropped (no error flag).

Read path:
- Each port samples its index at posedge N; read_data is valid after that edge and holds until the next edge (latency 1).
- Read value priority:
  1. index>=DEPTH -> 0.
  2. ZERO_REG=1 and index=0 -> 0.
  3. BYPASS=1 and an accepted write to the same index at the same edge -> write_data.
  4. Otherwise -> stored value before the edge.
- Ports A and B are independent. Both may read the same index; both receive identical data.

Clear FSM (IDLE, SWEEP):
- IDLE:
  - clear_start=1 at an edge -> SWEEP, ptr=0, clear_busy=1 after that edge.
  - A write accepted at that same edge still takes effect; the sweep overwrites it later.
- SWEEP, each edge:
  - reg[ptr] <= 0.
  - If ptr=DEPTH-1: go to IDLE, clear_busy=0 after the edge. Otherwise ptr <= ptr+1.
- clear_busy is high for exactly DEPTH cycles.
- clear_start while busy is ignored; it is not queued.
- Reads during SWEEP return stored contents. A read of reg[ptr] at the edge that clears it returns the pre-clear value; the clear is not bypassed.
- Writes during SWEEP are dropped.

Test Plan:
1. Reset, then write 0x1234 to index 3 and 0xBEEF to index 5. Read A=3, B=5 -> next cycle read_data_a=0x1234, read_data_b=0xBEEF.
2. Same-edge write 0x00AA to index 2 while both ports read 2:
   - BYPASS=1 -> both ports 0x00AA that cycle.
   - BYPASS=0 -> both ports show the old value that cycle, then 0x00AA on the next read.
3. ZERO_REG=1: write 0xFFFF to index 0, then read index 0 -> 0x0000. Write 0x0042 to index 1 -> reads back 0x0042.
4. Fill all 8 registers with 0x1111*(i+1), then pulse clear_start:
   - clear_busy high for exactly 8 cycles;
   - a write of 0x5555 to index 7 during the sweep is dropped;
   - afterwards every index reads 0;
   - a second clear_start during busy does not extend clear_busy.
5. Drop reset_n asynchronously mid-sweep (between clock edges) -> clear_busy and both read_data outputs are 0 immediately. After release, all registers read 0 and a new write/read works normally.
6. With DEPTH=6, write 0x7777 to index 7 and read index 7 -> write dropped and read returns 0. Index 5 is still writable and readable.
